mul_seq: RTL and testbench
==========================

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  EX-stage request to begin an operation.
REQ-005 SHALL have port funct  input  11  instruction opcode field from the decode stage.
REQ-006 SHALL have port a  input  WIDTH  multiplicand.
REQ-007 SHALL have port b  input  WIDTH  multiplier.
REQ-008 SHALL have port flush  input  1  pipeline flush; aborts any operation.
REQ-009 SHALL have port stall  output  1  freezes IF/ID/EX pipeline registers.
REQ-010 SHALL have port busy  output  1  high while state is RUN.
REQ-011 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-012 SHALL have port result  output  WIDTH  low WIDTH bits of a*b.

Function
REQ-013 SHALL recognise MUL as funct == 11'b10011011000 (ismul); other funct values SHALL never start an operation.
REQ-014 SHALL implement states IDLE, RUN, DONE.
REQ-015 IDLE -> RUN when start & ismul & !flush; multiplicand, multiplier and zeroed accumulator SHALL be latched on that edge, with the iteration counter set to 0.
REQ-016 In RUN, each cycle SHALL add the shifted multiplicand to the accumulator if multiplier bit 0 is 1, then shift the multiplicand left 1 and the multiplier right 1, and increment the counter.
REQ-017 Accumulator arithmetic SHALL be modulo 2^WIDTH; carries out of bit WIDTH-1 SHALL be discarded.
REQ-018 RUN -> DONE on the edge where the counter reaches WIDTH-1, i.e. exactly WIDTH cycles in RUN; no early termination for zero operands.
REQ-019 DONE -> IDLE unconditionally after one cycle; done SHALL be 1 only in DONE.
REQ-020 result SHALL present the final accumulator from entry to DONE and hold it until the next accepted start.
REQ-021 stall SHALL equal (IDLE & start & ismul & !flush) | RUN, combinationally, so the issuing instruction stays in EX; stall SHALL be 0 in DONE.
REQ-022 start asserted in RUN or DONE SHALL be ignored; start in DONE SHALL NOT re-launch (the held EX instruction deasserts start in the cycle after DONE).
REQ-023 flush in RUN SHALL return to IDLE on the next edge with no done pulse; result SHALL keep its previous value.
REQ-024 flush in DONE SHALL NOT suppress done (the result has already been produced).
REQ-025 Simultaneous start & ismul & flush in IDLE: flush SHALL win; no operation starts and stall SHALL be 0.
REQ-026 Counter width SHALL be $clog2(WIDTH) bits and SHALL NOT wrap within an operation.

Reset
REQ-027 reset SHALL immediately force state IDLE, counter 0, accumulator 0, result 0, done 0, busy 0, and stall 0 (no start is accepted while reset is high).
REQ-028 reset asserted mid-RUN SHALL abort without a done pulse; the first start after release SHALL behave as from cold reset.

Verification
REQ-029 WIDTH=64, a=3, b=5, start for 1 cycle at edge T -> stall high at T-1..T+63, busy T..T+63, done=1 and result=15 in cycle T+64, stall=0 in that cycle.
REQ-030 a=b=2^64-1 -> result=1 (wrap); a=0x1234, b=0 -> result=0 after the full 64 RUN cycles.
REQ-031 start with funct=11'b10001011000 (ADD) -> stall, busy, and done stay 0; state stays IDLE.
REQ-032 flush at the 10th RUN cycle -> IDLE next edge, no done, result unchanged; a second start then gives the correct product.
REQ-033 reset pulsed at the 30th RUN cycle -> all outputs 0 immediately; start, flush, and ismul together in IDLE -> no launch, stall=0.

Source files
------------

// File: rtl/mul_seq_if.sv
// Request/response bundle between the EX stage and the sequential multiplier.
// The EX stage drives the operands and the request; the multiplier returns the pipeline stall and the result.
interface mul_seq_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [10:0]      funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, funct, a, b, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, funct, a, b, flush,
    output stall, busy, done, result
  );
endinterface

// File: rtl/mul_seq.sv
// Shift-and-add multiplier: one multiplier bit per cycle, for exactly WIDTH cycles.
// Returns the low WIDTH bits of a*b. The pipeline is held in stall while the operation runs.
module mul_seq #(
  parameter int WIDTH = 64
) (
  input  logic      clk,
  input  logic      reset,
  mul_seq_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);
  localparam logic [10:0]    FUNCT_MUL = 11'b10011011000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] result_reg, result_next;

  logic             ismul;
  logic             launch;
  logic             last_cycle;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] acc_sum;

  assign ismul      = (bus.funct == FUNCT_MUL);
  // Flush has priority over a new request in the same cycle.
  assign launch     = (state_reg == S_IDLE) && bus.start && ismul && !bus.flush;
  assign last_cycle = (cnt_reg == LAST_CNT);

  // Partial product: the current multiplicand gated by the low multiplier bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pp
      assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end
  endgenerate

  // The carry out of the top bit is dropped, so the sum is modulo 2^WIDTH.
  assign acc_sum = acc_reg + addend;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (launch) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          state_next = S_IDLE;
        end else if (last_cycle) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy  = (state_reg == S_RUN);
    bus.done  = (state_reg == S_DONE);
    // The reset term blocks the combinational launch path while reset is held.
    bus.stall = (launch && !reset) || (state_reg == S_RUN);
  end

  assign bus.result = result_reg;

  // Datapath next values
  always_comb begin
    cnt_next    = cnt_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    result_next = result_reg;
    case (state_reg)
      S_IDLE: begin
        if (launch) begin
          mcand_next  = bus.a;
          mplier_next = bus.b;
          acc_next    = '0;
          cnt_next    = '0;
        end
      end
      S_RUN: begin
        if (!bus.flush) begin
          acc_next    = acc_sum;
          mcand_next  = mcand_reg << 1;
          mplier_next = mplier_reg >> 1;
          // The counter stops at its last value instead of wrapping.
          if (last_cycle) begin
            result_next = acc_sum;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
    end else begin
      cnt_reg    <= cnt_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      result_reg <= result_next;
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: checks latency, wrap-around products, non-MUL opcodes, flush and reset aborts.
module tb_mul_seq;

  localparam logic [10:0] MUL = 11'b10011011000;
  localparam logic [10:0] ADD = 11'b10001011000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [63:0] prev_result;

  mul_seq_if #(.WIDTH(64)) mif ();

  mul_seq #(.WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Issue one MUL, hold start through RUN and DONE like a stalled EX stage, then verify timing and result.
  task automatic run_mul(input string tag, input logic [63:0] x, input logic [63:0] y,
                         input logic [63:0] exp);
    int run_cycles;
    mif.a     = x;
    mif.b     = y;
    mif.funct = MUL;
    mif.flush = 1'b0;
    mif.start = 1'b1;
    #1;
    chk({tag, " stall_on_issue"}, 64'(mif.stall), 64'd1);
    chk({tag, " busy_on_issue"}, 64'(mif.busy), 64'd0);
    run_cycles = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (mif.busy && mif.stall && !mif.done) run_cycles++;
    end
    chk({tag, " run_cycles"}, 64'(run_cycles), 64'd64);
    step();
    chk({tag, " done"}, 64'(mif.done), 64'd1);
    chk({tag, " result"}, mif.result, exp);
    chk({tag, " stall_in_done"}, 64'(mif.stall), 64'd0);
    chk({tag, " busy_in_done"}, 64'(mif.busy), 64'd0);
    mif.start = 1'b0;
    step();
    chk({tag, " done_after"}, 64'(mif.done), 64'd0);
    chk({tag, " busy_after"}, 64'(mif.busy), 64'd0);
    chk({tag, " result_held"}, mif.result, exp);
    $display("op %s a=0x%h b=0x%h result=0x%h", tag, x, y, mif.result);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    mif.start = 1'b0;
    mif.funct = '0;
    mif.a = '0;
    mif.b = '0;
    mif.flush = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("reset busy", 64'(mif.busy), 64'd0);
    chk("reset done", 64'(mif.done), 64'd0);
    chk("reset stall", 64'(mif.stall), 64'd0);
    chk("reset result", mif.result, 64'd0);
    step();
    step();
    reset = 1'b0;
    step();

    run_mul("mul3x5", 64'd3, 64'd5, 64'd15);
    run_mul("ones_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    run_mul("zero_b", 64'h1234, 64'd0, 64'd0);
    run_mul("top_bit_out", 64'h8000_0000_0000_0000, 64'd2, 64'd0);
    run_mul("wide", 64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);

    // Non-MUL opcode must never launch.
    mif.funct = ADD;
    mif.a = 64'd7;
    mif.b = 64'd8;
    mif.start = 1'b1;
    #1;
    chk("add stall", 64'(mif.stall), 64'd0);
    step();
    chk("add busy", 64'(mif.busy), 64'd0);
    step();
    step();
    chk("add done", 64'(mif.done), 64'd0);
    chk("add result", mif.result, 64'hFFFF_FFFF_FFFF_FFFF);
    mif.start = 1'b0;
    $display("op add_ignored busy=%0d done=%0d", mif.busy, mif.done);

    // Flush at the 10th RUN cycle.
    prev_result = 64'hFFFF_FFFF_FFFF_FFFF;
    mif.funct = MUL;
    mif.a = 64'd100;
    mif.b = 64'd200;
    mif.start = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("flush busy_before", 64'(mif.busy), 64'd1);
    mif.flush = 1'b1;
    mif.start = 1'b0;
    step();
    chk("flush busy", 64'(mif.busy), 64'd0);
    chk("flush done", 64'(mif.done), 64'd0);
    chk("flush stall", 64'(mif.stall), 64'd0);
    chk("flush result", mif.result, prev_result);
    mif.flush = 1'b0;
    step();
    chk("flush done_later", 64'(mif.done), 64'd0);
    $display("op flush_abort result=0x%h", mif.result);
    run_mul("after_flush", 64'd7, 64'd9, 64'd63);

    // Reset at the 30th RUN cycle, start still held.
    mif.a = 64'h55;
    mif.b = 64'd3;
    mif.start = 1'b1;
    for (int i = 0; i < 30; i++) step();
    chk("rst busy_before", 64'(mif.busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst busy", 64'(mif.busy), 64'd0);
    chk("rst stall", 64'(mif.stall), 64'd0);
    chk("rst done", 64'(mif.done), 64'd0);
    chk("rst result", mif.result, 64'd0);
    step();
    reset = 1'b0;
    mif.flush = 1'b1;
    #1;
    chk("flush_wins stall", 64'(mif.stall), 64'd0);
    step();
    chk("flush_wins busy", 64'(mif.busy), 64'd0);
    chk("flush_wins done", 64'(mif.done), 64'd0);
    mif.flush = 1'b0;
    mif.start = 1'b0;
    step();
    $display("op reset_abort result=0x%h", mif.result);
    run_mul("after_reset", 64'd11, 64'd13, 64'd143);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
